stage_sequencer: RTL

Parametrised N-stage run controller for the chest X-ray classifier top level. Runs one image through a configurable chain of processing stages (accelerator, batch-norm, final classifier, and future stages) using per-stage start/done handshakes. Adds a per-stage skip mask, a per-stage timeout with the index of the failing stage, an explicit done/ack handshake, and an optional single retry on timeout.

---
 rtl/stage_sequencer_if.sv | 38 +++
 rtl/stage_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer_if.sv
// stage_sequencer_if: handshake/status bundle between the run controller
// (slave modport) and the top level that drives it (master modport).
//   start, weights_loaded, memory_ready, stage_skip, stage_done, ack : to sequencer
//   stage_en, stage_start, stage_idx, busy, ready_for_image, done,
//   error, error_stage, retry_used, cycle_count                      : from sequencer
interface stage_sequencer_if #(
  parameter int NUM_STAGES = 4,
  parameter int IDX_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
);
  logic                  start;
  logic                  weights_loaded;
  logic                  memory_ready;
  logic [NUM_STAGES-1:0] stage_skip;
  logic [NUM_STAGES-1:0] stage_done;
  logic                  ack;
  logic [NUM_STAGES-1:0] stage_en;
  logic                  stage_start;
  logic [IDX_W-1:0]      stage_idx;
  logic                  busy;
  logic                  ready_for_image;
  logic                  done;
  logic                  error;
  logic [IDX_W-1:0]      error_stage;
  logic                  retry_used;
  logic [31:0]           cycle_count;

  modport master (
    output start, weights_loaded, memory_ready, stage_skip, stage_done, ack,
    input  stage_en, stage_start, stage_idx, busy, ready_for_image, done,
           error, error_stage, retry_used, cycle_count
  );

  modport slave (
    input  start, weights_loaded, memory_ready, stage_skip, stage_done, ack,
    output stage_en, stage_start, stage_idx, busy, ready_for_image, done,
           error, error_stage, retry_used, cycle_count
  );
endinterface

// File: rtl/stage_sequencer.sv
// stage_sequencer: N-stage run controller. Runs one image through a chain of
// stages using per-stage start/done handshakes, with a per-stage skip mask,
// per-stage timeout (reporting the failing stage), done/ack handshake and a
// saturating ARM+RUN cycle counter.
// Ports:
//   clk  - clock
//   rst  - synchronous, active-high reset
//   bus  - stage_sequencer_if.slave (start/skip/done/ack in; enables/status out)
// Optional feature macro: SEQ_RETRY_EN -- when defined, the first timeout of a
// run retries the same stage once (retry_used=1); otherwise any timeout ends
// in ERROR and retry_used stays 0.
module stage_sequencer #(
  parameter int NUM_STAGES    = 4,
  parameter int TIMEOUT_LIMIT = 100000,
  parameter int TIMER_W       = 20,
  parameter int IDX_W         = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input logic                clk,
  input logic                rst,
  stage_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [IDX_W-1:0]      r_idx;
  logic [NUM_STAGES-1:0] r_skip;
  logic [TIMER_W-1:0]    r_timer;
  logic                  r_retry_used;
  logic [31:0]           r_cycle_count;

  logic                  w_ready;
  logic                  w_accept;
  logic [NUM_STAGES-1:0] w_onehot;
  logic                  w_cur_done;
  logic                  w_timeout;
  logic                  w_retry_ok;
  logic [IDX_W-1:0]      w_first_idx;
  logic                  w_first_valid;
  logic [IDX_W-1:0]      w_next_idx;
  logic                  w_next_valid;

  assign w_ready   = (r_state == S_IDLE) && bus.weights_loaded && bus.memory_ready;
  assign w_accept  = w_ready && bus.start;
  assign w_timeout = (r_timer == TIMER_W'(TIMEOUT_LIMIT - 1));

`ifdef SEQ_RETRY_EN
  assign w_retry_ok = ~r_retry_used;
`else
  assign w_retry_ok = 1'b0;
`endif

  // Active-stage decode; the done bit is picked through the one-hot mask so
  // inactive stages can never influence the sequence.
  always_comb begin
    w_onehot = '0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      w_onehot[i] = (r_idx == IDX_W'(i));
    end
  end

  assign w_cur_done = |(bus.stage_done & w_onehot);

  // First non-skipped stage from the live mask (used at acceptance) and the
  // next non-skipped stage above r_idx from the latched mask.
  always_comb begin
    w_first_idx   = '0;
    w_first_valid = 1'b0;
    w_next_idx    = '0;
    w_next_valid  = 1'b0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      if (!w_first_valid && !bus.stage_skip[i]) begin
        w_first_idx   = IDX_W'(i);
        w_first_valid = 1'b1;
      end
      if (!w_next_valid && !r_skip[i] && (i > 32'(r_idx))) begin
        w_next_idx   = IDX_W'(i);
        w_next_valid = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; completion takes priority over a coincident timeout.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_first_valid ? S_ARM : S_DONE;
        end
      end
      S_ARM:  w_state_nxt = S_RUN;
      S_RUN: begin
        if (w_cur_done) begin
          w_state_nxt = w_next_valid ? S_ARM : S_DONE;
        end else if (w_timeout) begin
          w_state_nxt = w_retry_ok ? S_ARM : S_ERROR;
        end
      end
      S_DONE:  if (bus.ack) w_state_nxt = S_IDLE;
      S_ERROR: if (bus.ack) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Run datapath: index, latched skip mask, stage timer, retry flag, counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx         <= '0;
      r_skip        <= '0;
      r_timer       <= '0;
      r_retry_used  <= 1'b0;
      r_cycle_count <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_skip        <= bus.stage_skip;
            r_cycle_count <= '0;
            r_retry_used  <= 1'b0;
            r_idx         <= w_first_valid ? w_first_idx : '0;
          end
        end
        S_ARM: begin
          r_timer <= '0;
          if (r_cycle_count != '1) r_cycle_count <= r_cycle_count + 32'd1;
        end
        S_RUN: begin
          r_timer <= r_timer + TIMER_W'(1);
          if (r_cycle_count != '1) r_cycle_count <= r_cycle_count + 32'd1;
          if (w_cur_done) begin
            if (w_next_valid) r_idx <= w_next_idx;
          end else if (w_timeout && w_retry_ok) begin
            r_retry_used <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Moore outputs decoded from registered state
  always_comb begin
    bus.stage_en    = '0;
    bus.stage_start = 1'b0;
    bus.busy        = 1'b0;
    bus.done        = 1'b0;
    bus.error       = 1'b0;
    bus.error_stage = '0;
    unique case (r_state)
      S_ARM: begin
        bus.stage_en    = w_onehot;
        bus.stage_start = 1'b1;
        bus.busy        = 1'b1;
      end
      S_RUN: begin
        bus.stage_en = w_onehot;
        bus.busy     = 1'b1;
      end
      S_DONE:  bus.done = 1'b1;
      S_ERROR: begin
        bus.error       = 1'b1;
        bus.error_stage = r_idx;
      end
      default: ;
    endcase
  end

  assign bus.stage_idx       = r_idx;
  assign bus.retry_used      = r_retry_used;
  assign bus.cycle_count     = r_cycle_count;
  assign bus.ready_for_image = w_ready;

endmodule
